multicast_fanout: RTL and testbench

- Broadcast/scatter counterpart of the per-router reduction switch.
- Takes one flit from the local injection/collective engine and replicates it to every torus direction selected by a destination mask (XPOS..ZNEG).
- Holds the flit until every selected direction has accepted its copy, then frees the input.
- Sits between the collective engine and the six router output ports. Handshakes use the same valid/avail scheme as the switch.

---
 rtl/multicast_fanout_pkg.sv | 51 +++++
 rtl/multicast_fanout_port_tracker.sv | 42 ++++
 rtl/multicast_fanout.sv | 125 ++++++++++++
 tb/tb_multicast_fanout.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multicast_fanout_pkg.sv
// -----------------------------------------------------------------------------
// multicast_fanout_pkg
// Definitions shared by the multicast fan-out block, the router switch and the
// reduction tree: torus direction encodings, the port count, flit width
// derivations and the direction <-> destination-mask mapping.
// -----------------------------------------------------------------------------
package multicast_fanout_pkg;

  // Six torus directions; fixed by the router microarchitecture.
  localparam int PORT_NUM  = 6;
  // Bits needed to encode one direction index.
  localparam int ROUTE_LEN = 3;

  // Default flit geometry: the valid bit sits at VALID_BIT_POS and the
  // children field (LG_NUMPROCS bits) sits above it.
  localparam int VALID_BIT_POS    = 81;
  localparam int LG_NUMPROCS      = 3;
  localparam int FLIT_WIDTH       = VALID_BIT_POS + 1;
  localparam int FLIT_CHILD_WIDTH = VALID_BIT_POS + 1 + LG_NUMPROCS;

  // Destination-mask bit k corresponds to direction k.
  typedef enum logic [ROUTE_LEN-1:0] {
    DIR_XPOS = 3'd0,
    DIR_YPOS = 3'd1,
    DIR_ZPOS = 3'd2,
    DIR_XNEG = 3'd3,
    DIR_YNEG = 3'd4,
    DIR_ZNEG = 3'd5
  } dir_e;

  // Fan-out controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } fanout_state_e;

  // One-hot destination mask selecting a single direction.
  function automatic logic [PORT_NUM-1:0] dir_to_mask(input dir_e d);
    logic [PORT_NUM-1:0] m;
    m = '0;
    m[d] = 1'b1;
    return m;
  endfunction

  // Flit-with-children width for a given valid-bit position and child field.
  function automatic int flit_child_width(input int valid_bit_pos,
                                          input int lg_nprocs);
    return valid_bit_pos + 1 + lg_nprocs;
  endfunction

endpackage

// File: rtl/multicast_fanout_port_tracker.sv
// -----------------------------------------------------------------------------
// fanout_port_tracker
// Tracks whether one direction still owes the downstream port a copy of the
// current multicast flit.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   i_load     a new flit is being accepted this cycle (any mask)
//   i_load_val destination-mask bit for this direction of the new flit
//   i_avail    downstream port accepts this cycle
//   o_pending  copy still outstanding (registered)
//   o_blocked  copy outstanding and not taken this cycle (combinational)
// -----------------------------------------------------------------------------
module fanout_port_tracker (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_load_val,
  input  logic i_avail,
  output logic o_pending,
  output logic o_blocked
);

  logic r_pending;

  // A loaded flit overrides the drain: when the previous flit finishes in the
  // same cycle its pending bit is already clear or being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (i_load) begin
      r_pending <= i_load_val;
    end else begin
      r_pending <= r_pending & ~i_avail;
    end
  end

  assign o_pending = r_pending;
  assign o_blocked = r_pending & ~i_avail;

endmodule

// File: rtl/multicast_fanout.sv
// -----------------------------------------------------------------------------
// multicast_fanout
// Replicates one flit from the collective engine onto every torus direction
// selected by a destination mask, holding it until every selected direction
// has taken its copy.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   in            flit to multicast
//   in_dest_mask  bit k selects direction k (XPOS,YPOS,ZPOS,XNEG,YNEG,ZNEG)
//   in_valid      in / in_dest_mask valid
//   in_avail      block accepts a flit this cycle (combinational)
//   out           slice k = copy for direction k
//   out_valid     copy pending on direction k
//   out_avail     downstream k accepts this cycle
//   flit_cnt      completed multicasts (wrapping)
//   drop_cnt      flits accepted with an empty mask (wrapping)
//   stall_err     sticky: a pending flit waited STALL_LIMIT cycles
// -----------------------------------------------------------------------------
module multicast_fanout
  import multicast_fanout_pkg::*;
#(
  parameter  int ValidBitPos    = VALID_BIT_POS,
  parameter  int lg_numprocs    = LG_NUMPROCS,
  parameter  int STALL_LIMIT    = 1024,
  localparam int FlitWidth      = ValidBitPos + 1,
  localparam int FlitChildWidth = FlitWidth + lg_numprocs
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitChildWidth-1:0]          in,
  input  logic [PORT_NUM-1:0]                in_dest_mask,
  input  logic                               in_valid,
  output logic                               in_avail,
  output logic [PORT_NUM*FlitChildWidth-1:0] out,
  output logic [PORT_NUM-1:0]                out_valid,
  input  logic [PORT_NUM-1:0]                out_avail,
  output logic [15:0]                        flit_cnt,
  output logic [15:0]                        drop_cnt,
  output logic                               stall_err
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  fanout_state_e             r_state;
  logic [FlitChildWidth-1:0] r_flit_q;
  logic [STALL_W-1:0]        r_stall_cnt;
  logic [15:0]               r_flit_cnt;
  logic [15:0]               r_drop_cnt;
  logic                      r_stall_err;

  logic [PORT_NUM-1:0]       w_pending;
  logic [PORT_NUM-1:0]       w_blocked;
  logic                      w_send;
  logic                      w_done_now;
  logic                      w_accept;
  logic                      w_mask_nz;

  assign w_send     = (r_state == ST_SEND);
  // The flit is finished when no selected direction is left waiting after
  // this cycle's handshakes.
  assign w_done_now = w_send && (w_blocked == '0);
  assign in_avail   = !w_send || w_done_now;
  assign w_accept   = in_valid && in_avail;
  assign w_mask_nz  = (in_dest_mask != '0);

  // One pending-copy tracker per torus direction.
  for (genvar k = 0; k < PORT_NUM; k++) begin : g_port
    fanout_port_tracker u_tracker (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept),
      .i_load_val (in_dest_mask[k]),
      .i_avail    (out_avail[k]),
      .o_pending  (w_pending[k]),
      .o_blocked  (w_blocked[k])
    );
    assign out[k*FlitChildWidth +: FlitChildWidth] = r_flit_q;
  end

  assign out_valid = w_send ? w_pending : '0;
  assign flit_cnt  = r_flit_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign stall_err = r_stall_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flit_q    <= '0;
      r_stall_cnt <= '0;
      r_flit_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_stall_err <= 1'b0;
    end else begin
      if (w_done_now) begin
        r_flit_cnt <= r_flit_cnt + 16'd1;
      end

      if (w_accept) begin
        if (w_mask_nz) begin
          r_flit_q    <= in;
          r_state     <= ST_SEND;
          r_stall_cnt <= '0;
        end else begin
          // Nothing to send: the flit is discarded and only counted.
          r_drop_cnt <= r_drop_cnt + 16'd1;
          r_state    <= ST_IDLE;
        end
      end else if (w_done_now) begin
        r_state <= ST_IDLE;
      end else if (w_send) begin
        // Stuck flit: count up to the limit and flag once; it keeps waiting.
        if (r_stall_cnt != STALL_MAX) begin
          r_stall_cnt <= r_stall_cnt + STALL_W'(1);
          if (r_stall_cnt == STALL_MAX - STALL_W'(1)) begin
            r_stall_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multicast_fanout.sv
module tb_multicast_fanout;

  localparam int PN  = 6;
  localparam int FCW = 85;
  localparam int OW  = PN * FCW;

  logic           clk;
  logic           rst;
  logic [FCW-1:0] d_in;
  logic [PN-1:0]  d_mask;
  logic           d_valid;
  logic           in_avail;
  logic [OW-1:0]  out;
  logic [PN-1:0]  out_valid;
  logic [PN-1:0]  out_avail;
  logic [15:0]    flit_cnt;
  logic [15:0]    drop_cnt;
  logic           stall_err;

  int n_cmp = 0;
  int n_err = 0;

  // Expected copies per direction, in the order each must appear.
  logic [FCW-1:0] exp_q [PN][$];

  multicast_fanout #(.STALL_LIMIT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (d_in),
    .in_dest_mask (d_mask),
    .in_valid     (d_valid),
    .in_avail     (in_avail),
    .out          (out),
    .out_valid    (out_valid),
    .out_avail    (out_avail),
    .flit_cnt     (flit_cnt),
    .drop_cnt     (drop_cnt),
    .stall_err    (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PN-1:0] m, input logic [FCW-1:0] d);
    for (int k = 0; k < PN; k++)
      if (m[k]) exp_q[k].push_back(d);
  endtask

  // Monitor: every handshake on an output direction must match the next
  // expected copy for that direction.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < PN; k++) begin
        if (out_valid[k] && out_avail[k]) begin
          logic [FCW-1:0] e;
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_copy dir%0d: got data %0h, required no transfer",
                     k, out[k*FCW +: FCW]);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("copy_dir%0d", k), 512'(out[k*FCW +: FCW]), 512'(e));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    logic [FCW-1:0] fa, fb, fc, fd, fe;
    int left;
    fa = 85'h0A5;
    fb = 85'h1C_DEAD_BEEF_0123_4567;
    fc = 85'h0F_1111_2222_3333_4444;
    fd = 85'h15_CAFE_F00D_0000_0077;
    fe = 85'h03_0000_0000_0000_0EEE;

    rst = 1'b1; d_in = '0; d_mask = '0; d_valid = 1'b0; out_avail = '1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_in_avail",  512'(in_avail),  512'(1'b1));
    check("rst_out_valid", 512'(out_valid), 512'(6'b0));
    check("rst_flit_cnt",  512'(flit_cnt),  512'(16'd0));
    check("rst_drop_cnt",  512'(drop_cnt),  512'(16'd0));
    check("rst_stall_err", 512'(stall_err), 512'(1'b0));

    // Single direction, always-ready downstream.
    d_in = fa; d_mask = 6'b000001; d_valid = 1'b1; push(d_mask, fa);
    tick();
    d_valid = 1'b0; #1;
    check("t1_out_valid", 512'(out_valid), 512'(6'b000001));
    check("t1_data0",     512'(out[0 +: FCW]), 512'(fa));
    check("t1_in_avail",  512'(in_avail),  512'(1'b1));
    tick();
    check("t1_flit_cnt",  512'(flit_cnt),  512'(16'd1));
    check("t1_idle_valid", 512'(out_valid), 512'(6'b0));

    // All directions, split acceptance over two cycles.
    d_in = fb; d_mask = 6'b111111; d_valid = 1'b1; push(d_mask, fb);
    tick();
    d_valid = 1'b0; out_avail = 6'b000101; #1;
    check("t2_in_avail_low", 512'(in_avail),  512'(1'b0));
    check("t2_valid_all",    512'(out_valid), 512'(6'b111111));
    tick();
    check("t2_pending", 512'(out_valid), 512'(6'b111010));
    out_avail = 6'b111010; #1;
    check("t2_in_avail_back", 512'(in_avail), 512'(1'b1));
    tick();
    check("t2_done_valid", 512'(out_valid), 512'(6'b0));
    check("t2_flit_cnt",   512'(flit_cnt),  512'(16'd2));
    out_avail = '1;

    // Back-to-back flits with no bubble.
    d_in = fc; d_mask = 6'b000011; d_valid = 1'b1; push(d_mask, fc);
    tick();
    check("t3_a_valid", 512'(out_valid), 512'(6'b000011));
    check("t3_a_data1", 512'(out[FCW +: FCW]), 512'(fc));
    d_in = fd; d_mask = 6'b100000; push(d_mask, fd); #1;
    check("t3_b_in_avail", 512'(in_avail), 512'(1'b1));
    tick();
    d_valid = 1'b0;
    check("t3_b_valid",  512'(out_valid), 512'(6'b100000));
    check("t3_b_data5",  512'(out[5*FCW +: FCW]), 512'(fd));
    check("t3_cnt_mid",  512'(flit_cnt), 512'(16'd3));
    tick();
    check("t3_flit_cnt", 512'(flit_cnt), 512'(16'd4));
    check("t3_idle",     512'(out_valid), 512'(6'b0));

    // Empty mask: accepted and dropped.
    d_in = fe; d_mask = 6'b000000; d_valid = 1'b1; #1;
    check("t4_in_avail", 512'(in_avail), 512'(1'b1));
    tick();
    d_valid = 1'b0;
    check("t4_out_valid", 512'(out_valid), 512'(6'b0));
    check("t4_drop_cnt",  512'(drop_cnt),  512'(16'd1));
    check("t4_flit_cnt",  512'(flit_cnt),  512'(16'd4));

    // Stalled direction trips the sticky error at 16 cycles.
    d_in = fd; d_mask = 6'b010000; d_valid = 1'b1; out_avail = 6'b101111;
    push(d_mask, fd);
    tick();
    d_valid = 1'b0;
    check("t5_err_start", 512'(stall_err), 512'(1'b0));
    repeat (15) tick();
    check("t5_err_15",    512'(stall_err), 512'(1'b0));
    check("t5_valid_15",  512'(out_valid), 512'(6'b010000));
    check("t5_in_avail",  512'(in_avail),  512'(1'b0));
    tick();
    check("t5_err_16",    512'(stall_err), 512'(1'b1));
    repeat (4) tick();
    check("t5_valid_held", 512'(out_valid), 512'(6'b010000));
    check("t5_data_held",  512'(out[4*FCW +: FCW]), 512'(fd));
    out_avail = '1;
    tick();
    check("t5_done_valid", 512'(out_valid), 512'(6'b0));
    check("t5_flit_cnt",   512'(flit_cnt),  512'(16'd5));
    check("t5_err_sticky", 512'(stall_err), 512'(1'b1));

    // Reset in the middle of a send loses the flit.
    d_in = fe; d_mask = 6'b001100; d_valid = 1'b1; out_avail = '0;
    tick();
    d_valid = 1'b0;
    check("t6_pending", 512'(out_valid), 512'(6'b001100));
    rst = 1'b1;
    exp_q[2].delete();
    exp_q[3].delete();
    tick();
    rst = 1'b0; #1;
    check("t6_out_valid", 512'(out_valid), 512'(6'b0));
    check("t6_in_avail",  512'(in_avail),  512'(1'b1));
    check("t6_flit_cnt",  512'(flit_cnt),  512'(16'd0));
    check("t6_drop_cnt",  512'(drop_cnt),  512'(16'd0));
    check("t6_stall_err", 512'(stall_err), 512'(1'b0));
    check("t6_out_zero",  512'(out),       512'(0));
    out_avail = '1;
    repeat (3) tick();
    check("t6_no_reemit", 512'(out_valid), 512'(6'b0));

    left = 0;
    for (int k = 0; k < PN; k++) left += exp_q[k].size();
    check("leftover_copies", 512'(left), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
